// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Decode-to-sequencer strobe bundle and sequencer status
//                outputs. The decode side (master) drives the strobes and
//                flags; the sequencer (slave) drives the fetch address,
//                flush and stack status.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int STACK_DEPTH = 16
);
  localparam int c_SP_W = $clog2(STACK_DEPTH) + 1;

  logic                  hazard;
  logic                  p_cache_miss;
  logic                  pc_jmp;
  logic                  pc_call;
  logic                  pc_ret;
  logic                  pc_brx;
  logic                  pc_brxt;
  logic [1:0]            cond_sel;
  logic                  flag_n;
  logic                  flag_z;
  logic                  flag_p;
  logic [9:0]            I_field;
  logic [ADDR_WIDTH-1:0] jmp_target;
  logic [ADDR_WIDTH-1:0] prg_addr;
  logic                  flush;
  logic                  stack_overflow;
  logic                  stack_underflow;
  logic [c_SP_W-1:0]     sp;

  modport master (
    output hazard, p_cache_miss, pc_jmp, pc_call, pc_ret, pc_brx, pc_brxt,
           cond_sel, flag_n, flag_z, flag_p, I_field, jmp_target,
    input  prg_addr, flush, stack_overflow, stack_underflow, sp
  );

  modport slave (
    input  hazard, p_cache_miss, pc_jmp, pc_call, pc_ret, pc_brx, pc_brxt,
           cond_sel, flag_n, flag_z, flag_p, I_field, jmp_target,
    output prg_addr, flush, stack_overflow, stack_underflow, sp
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter and hardware return stack. Sequences
//                instruction fetch, applies ret/call/jmp/branch redirects in
//                priority order, raises a 2-cycle flush after each redirect
//                and freezes on hazard or program-cache miss.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    STACK_DEPTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pc_sequencer_if.slave      bus
);

  localparam int                    c_IDX_W      = $clog2(STACK_DEPTH);
  localparam int                    c_SP_W       = c_IDX_W + 1;
  localparam logic [c_SP_W-1:0]     c_SP_FULL    = c_SP_W'(STACK_DEPTH);
  localparam logic [c_SP_W-1:0]     c_SP_ZERO    = '0;
  localparam logic [c_SP_W-1:0]     c_SP_ONE     = c_SP_W'(1);
  localparam logic [c_IDX_W-1:0]    c_IDX_ONE    = c_IDX_W'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PC_ONE     = ADDR_WIDTH'(1);
  localparam logic [1:0]            c_FLUSH_LOAD = 2'd2;
  localparam logic [1:0]            c_FLUSH_ONE  = 2'd1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [c_SP_W-1:0]     r_sp;
  logic [1:0]            r_flush_cnt;
  logic                  r_ovf;
  logic                  r_unf;
  logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic                  w_stall;
  logic                  w_cond;
  logic                  w_taken;
  logic                  w_redirect;
  logic                  w_push;
  logic                  w_sp_empty;
  logic                  w_sp_full;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_br_target;
  logic [c_IDX_W-1:0]    w_push_idx;
  logic [c_IDX_W-1:0]    w_top_idx;

  assign w_stall     = bus.hazard | bus.p_cache_miss;
  assign w_cond      = ((bus.cond_sel == 2'b01) & bus.flag_n) |
                       ((bus.cond_sel == 2'b10) & bus.flag_z) |
                       ((bus.cond_sel == 2'b11) & bus.flag_p);
  assign w_taken     = bus.pc_brx & (w_cond ^ bus.pc_brxt);
  assign w_redirect  = bus.pc_ret | bus.pc_call | bus.pc_jmp | w_taken;
  assign w_sp_empty  = (r_sp == c_SP_ZERO);
  assign w_sp_full   = (r_sp == c_SP_FULL);
  assign w_pc_inc    = r_pc + c_PC_ONE;
  // Short branches stay in the current 1K page.
  assign w_br_target = {r_pc[ADDR_WIDTH-1:10], bus.I_field};
  assign w_push_idx  = r_sp[c_IDX_W-1:0];
  assign w_top_idx   = r_sp[c_IDX_W-1:0] - c_IDX_ONE;
  // A push happens only for a call that is not pre-empted by a ret and has room.
  assign w_push      = ~w_stall & ~bus.pc_ret & bus.pc_call & ~w_sp_full;

  // Return-stack storage: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  // Program counter, stack pointer, flush counter and sticky stack flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_VECTOR;
      r_sp        <= c_SP_ZERO;
      r_flush_cnt <= 2'd0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else if (!w_stall) begin
      if (bus.pc_ret) begin
        if (w_sp_empty) begin
          r_pc  <= RESET_VECTOR;
          r_unf <= 1'b1;
        end else begin
          r_pc <= r_stack[w_top_idx];
          r_sp <= r_sp - c_SP_ONE;
        end
      end else if (bus.pc_call) begin
        // The jump is taken even when the push must be dropped.
        r_pc <= bus.jmp_target;
        if (w_sp_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_sp <= r_sp + c_SP_ONE;
        end
      end else if (bus.pc_jmp) begin
        r_pc <= bus.jmp_target;
      end else if (w_taken) begin
        r_pc <= w_br_target;
      end else begin
        r_pc <= w_pc_inc;
      end

      if (w_redirect) begin
        r_flush_cnt <= c_FLUSH_LOAD;
      end else if (r_flush_cnt != 2'd0) begin
        r_flush_cnt <= r_flush_cnt - c_FLUSH_ONE;
      end
    end
  end

  assign bus.prg_addr        = r_pc;
  assign bus.sp              = r_sp;
  assign bus.flush           = (r_flush_cnt != 2'd0);
  assign bus.stack_overflow  = r_ovf;
  assign bus.stack_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. A queue-based model of
//                the fetch address, return stack and flush window is compared
//                against the DUT every cycle; directed scenarios pin both the
//                DUT and the model to hand-computed values, then random
//                traffic is applied.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int c_AW    = 16;
  localparam int c_DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_WIDTH(c_AW), .STACK_DEPTH(c_DEPTH)) bus ();

  pc_sequencer #(
    .ADDR_WIDTH  (c_AW),
    .STACK_DEPTH (c_DEPTH),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_ovf, m_unf;
  int          m_flush_left;
  bit          m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 16'h0000;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
      m_flush_left = 0;
      m_valid = 1;
    end else if (!(bus.hazard || bus.p_cache_miss)) begin
      bit c, tk, redir;
      c = (bus.cond_sel == 2'd1 && bus.flag_n) || (bus.cond_sel == 2'd2 && bus.flag_z) ||
          (bus.cond_sel == 2'd3 && bus.flag_p);
      tk = bus.pc_brx && (c != bus.pc_brxt);
      redir = 1;
      if (bus.pc_ret) begin
        if (m_stack.size() == 0) begin
          m_pc = 16'h0000;
          m_unf = 1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end else if (bus.pc_call) begin
        if (m_stack.size() == c_DEPTH) m_ovf = 1;
        else m_stack.push_back(m_pc + 16'd1);
        m_pc = bus.jmp_target;
      end else if (bus.pc_jmp) begin
        m_pc = bus.jmp_target;
      end else if (tk) begin
        m_pc = (m_pc & 16'hFC00) | {6'd0, bus.I_field};
      end else begin
        m_pc = m_pc + 16'd1;
        redir = 0;
      end
      if (redir) m_flush_left = 2;
      else if (m_flush_left > 0) m_flush_left--;
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_prg_addr", 32'(bus.prg_addr), 32'(m_pc));
      chk("cyc_sp", 32'(bus.sp), 32'(m_stack.size()));
      chk("cyc_flush", 32'(bus.flush), 32'(m_flush_left > 0));
      chk("cyc_ovf", 32'(bus.stack_overflow), 32'(m_ovf));
      chk("cyc_unf", 32'(bus.stack_underflow), 32'(m_unf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.hazard = 0; bus.p_cache_miss = 0; bus.pc_jmp = 0; bus.pc_call = 0;
    bus.pc_ret = 0; bus.pc_brx = 0; bus.pc_brxt = 0; bus.cond_sel = 2'd0;
    bus.flag_n = 0; bus.flag_z = 0; bus.flag_p = 0; bus.I_field = 10'd0;
    bus.jmp_target = 16'd0;
  endtask

  task automatic lit(input string nm, input logic [15:0] pc, input int sp, input bit fl);
    chk({nm, "_pc"}, 32'(bus.prg_addr), 32'(pc));
    chk({nm, "_model_pc"}, 32'(m_pc), 32'(pc));
    chk({nm, "_sp"}, 32'(bus.sp), 32'(sp));
    chk({nm, "_flush"}, 32'(bus.flush), 32'(fl));
  endtask

  task automatic jump_to(input logic [15:0] t);
    idle(); bus.pc_jmp = 1; bus.jmp_target = t;
    cyc(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    cyc(); cyc();
    lit("reset", 16'h0000, 0, 0);
    chk("reset_ovf", 32'(bus.stack_overflow), 0);
    chk("reset_unf", 32'(bus.stack_underflow), 0);
    rst = 0;
    cyc(); lit("seq1", 16'h0001, 0, 0);
    cyc(); lit("seq2", 16'h0002, 0, 0);
    cyc(); lit("seq3", 16'h0003, 0, 0);

    // call / ret
    jump_to(16'h0040);
    bus.pc_call = 1; bus.jmp_target = 16'h1234;
    cyc(); idle();
    lit("call", 16'h1234, 1, 1);
    cyc(); lit("call_f2", 16'h1235, 1, 1);
    cyc(); lit("call_f3", 16'h1236, 1, 0);
    cyc(); cyc();
    bus.pc_ret = 1;
    cyc(); idle();
    lit("ret", 16'h0041, 0, 1);
    cyc(); lit("ret_f2", 16'h0042, 0, 1);
    cyc(); lit("ret_f3", 16'h0043, 0, 0);

    // branch taken / not taken
    jump_to(16'h0C03); cyc(); cyc();
    bus.pc_brx = 1; bus.cond_sel = 2'b10; bus.flag_z = 1; bus.pc_brxt = 0; bus.I_field = 10'h3A0;
    cyc(); idle();
    lit("br_taken", 16'h0FA0, 0, 1);
    jump_to(16'h0C03); cyc(); cyc();
    lit("br_pre", 16'h0C05, 0, 0);
    bus.pc_brx = 1; bus.cond_sel = 2'b10; bus.flag_z = 1; bus.pc_brxt = 1; bus.I_field = 10'h3A0;
    cyc(); idle();
    lit("br_not", 16'h0C06, 0, 0);

    // jump held through a hazard
    bus.hazard = 1; bus.pc_jmp = 1; bus.jmp_target = 16'h2222;
    repeat (3) begin
      cyc(); lit("haz_hold", 16'h0C06, 0, 0);
    end
    bus.hazard = 0;
    cyc(); idle();
    lit("haz_jmp", 16'h2222, 0, 1);
    cyc(); lit("haz_next", 16'h2223, 0, 1);

    // stack overflow then underflow
    jump_to(16'h5000);
    for (int i = 0; i < 17; i++) begin
      bus.pc_call = 1; bus.jmp_target = 16'h3000 + 16'(i * 16);
      cyc();
    end
    idle();
    lit("ovf", 16'h3100, 16, 1);
    chk("ovf_flag", 32'(bus.stack_overflow), 1);
    bus.pc_ret = 1;
    cyc(); lit("ret_first", 16'h30E1, 15, 1);
    for (int i = 1; i < 16; i++) cyc();
    lit("ret_16", 16'h5001, 0, 1);
    chk("unf_before", 32'(bus.stack_underflow), 0);
    cyc(); idle();
    lit("ret_17", 16'h0000, 0, 1);
    chk("unf_flag", 32'(bus.stack_underflow), 1);

    // address wrap
    jump_to(16'hFFFE);
    cyc(); lit("wrap_ffff", 16'hFFFF, 0, 1);
    cyc(); lit("wrap_0", 16'h0000, 0, 0);

    // reset wins over a simultaneous call
    bus.pc_call = 1; bus.jmp_target = 16'h7777;
    cyc(); lit("pre_rst_call", 16'h7777, 1, 1);
    rst = 1; bus.jmp_target = 16'h6666;
    cyc(); rst = 0; idle();
    lit("rst_call", 16'h0000, 0, 0);
    chk("rst_ovf", 32'(bus.stack_overflow), 0);
    chk("rst_unf", 32'(bus.stack_underflow), 0);
    cyc(); lit("rst_after", 16'h0001, 0, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int s;
      idle();
      bus.hazard       = ($urandom_range(0, 99) < 15);
      bus.p_cache_miss = ($urandom_range(0, 99) < 8);
      bus.cond_sel     = 2'($urandom_range(0, 3));
      bus.flag_n       = 1'($urandom_range(0, 1));
      bus.flag_z       = 1'($urandom_range(0, 1));
      bus.flag_p       = 1'($urandom_range(0, 1));
      bus.pc_brxt      = 1'($urandom_range(0, 1));
      bus.I_field      = 10'($urandom_range(0, 1023));
      bus.jmp_target   = 16'($urandom_range(0, 65535));
      s = $urandom_range(0, 19);
      if (s < 4)       bus.pc_jmp  = 1;
      else if (s < 8)  bus.pc_call = 1;
      else if (s < 12) bus.pc_ret  = 1;
      else if (s < 15) bus.pc_brx  = 1;
      else if (s == 15) begin
        bus.pc_jmp  = 1'($urandom_range(0, 1));
        bus.pc_call = 1'($urandom_range(0, 1));
        bus.pc_ret  = 1'($urandom_range(0, 1));
        bus.pc_brx  = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 0; idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and call-stack controller that sequences instruction fetch for the CPU pipeline.
- Consumes the registered control strobes from the decode stage (pc_jmp, pc_brx, pc_brxt, pc_call, pc_ret, H_en/L_en, I_field) and the status flags, and produces the program-cache fetch address.
- Owns the hardware return stack and produces a flush pulse so fetch/decode discard wrong-path instructions after a redirect.
- Stalls on hazard and program-cache miss.

Parameters:
- ADDR_WIDTH, 16, program address width; must be ≥ 11.
- STACK_DEPTH, 16, return-stack entries; power of two, ≥ 2.
- RESET_VECTOR, 16'h0000, first fetch address after reset; also the target of a ret on an empty stack.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- hazard  in  1  pipeline stall from hazard logic.
- p_cache_miss  in  1  program-cache miss stall.
- pc_jmp  in  1  jump strobe from decode.
- pc_call  in  1  call strobe from decode.
- pc_ret  in  1  return strobe from decode.
- pc_brx  in  1  conditional-branch strobe from decode.
- pc_brxt  in  1  branch sense; 1 = branch-if-not.
- cond_sel  in  2  {H_en,L_en}; 00 = false, 01 = N, 10 = Z, 11 = P.
- flag_n  in  1  negative status flag.
- flag_z  in  1  zero status flag.
- flag_p  in  1  positive status flag.
- I_field  in  10  branch target, low bits.
- jmp_target  in  ADDR_WIDTH  jump/call target from register file (AUX0).
- prg_addr  out  ADDR_WIDTH  program fetch address.
- flush  out  1  high while wrong-path fetches must be squashed.
- stack_overflow  out  1  sticky; a call occurred with the stack full.
- stack_underflow  out  1  sticky; a ret occurred with the stack empty.
- sp  out  log2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH.

Behaviour:
- Reset values: prg_addr = RESET_VECTOR, flush = 0, sp = 0, stack_overflow = 0, stack_underflow = 0. Stack contents are not reset.
- Reset asserted mid-operation wins over every other input in that cycle.
- Stall: stall = hazard | p_cache_miss.
  - While stall = 1: prg_addr, sp, stack contents and the flush counter all hold; the strobes are ignored.
  - Because decode holds its strobes during a hazard, each strobe is acted on exactly once, in the first non-stalled cycle.
- Sequential fetch: when stall = 0 and no redirect, prg_addr <= prg_addr + 1, wrapping modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
- Condition: cond = (cond_sel==01 & flag_n) | (cond_sel==10 & flag_z) | (cond_sel==11 & flag_p).
- Branch taken: taken = pc_brx & (cond ^ pc_brxt). cond_sel = 00 with pc_brxt = 1 is the unconditional bra.
- Redirect priority, evaluated when stall = 0 (decode asserts at most one; the priority defines behaviour if more are asserted):
  1. pc_ret: prg_addr <= top of stack; sp <= sp-1.
     - If sp == 0: prg_addr <= RESET_VECTOR, stack_underflow <= 1, sp stays 0.
  2. pc_call: push (prg_addr + 1) into stack[sp]; sp <= sp+1; prg_addr <= jmp_target.
     - If sp == STACK_DEPTH: push dropped, stack_overflow <= 1, sp unchanged, jump still taken.
  3. pc_jmp: prg_addr <= jmp_target.
  4. taken: prg_addr <= {prg_addr[ADDR_WIDTH-1:10], I_field}; the page is taken from the current prg_addr.
- Flush: any redirect loads a 2-bit flush counter with 2.
  - flush = (counter != 0).
  - The counter decrements only in non-stalled cycles.
  - A new redirect while flush = 1 reloads it to 2.
  - Latency: flush rises the cycle after the redirect is accepted, coincident with the new prg_addr, and stays high for exactly 2 non-stalled cycles.
- Sticky flags clear only on rst.
- Stack is a register array indexed by sp; a push writes at index sp, the top of stack is stack[sp-1]. No combinational path from inputs to prg_addr; all outputs are registered.

Test Plan:
- Reset release, no strobes, RESET_VECTOR = 0 -> prg_addr = 0,1,2,3 on successive cycles; flush = 0; sp = 0.
- At prg_addr = 0x0040, pc_call with jmp_target = 0x1234, then pc_ret five cycles later -> 0x1234 with sp = 1; after ret, prg_addr = 0x0041 and sp = 0; flush high 2 cycles after each redirect.
- pc_brx, cond_sel = 10, flag_z = 1, pc_brxt = 0, prg_addr = 0x0C05, I_field = 0x3A0 -> prg_addr = 0x0FA0. Same stimulus with pc_brxt = 1 -> prg_addr = 0x0C06 and no flush.
- pc_jmp held for 3 hazard cycles, then hazard drops -> prg_addr frozen during the hazard, loads jmp_target exactly once, next cycle prg_addr = jmp_target + 1.
- 17 calls with STACK_DEPTH = 16 -> sp saturates at 16 and stack_overflow = 1. Then 17 rets -> the 17th returns to RESET_VECTOR, stack_underflow = 1, sp = 0.
- prg_addr = 0xFFFF, no stall -> 0x0000. rst asserted together with pc_call -> prg_addr = RESET_VECTOR, sp = 0, no push.
